// File: rtl/timer_counter.sv
// Parametrised timer/counter with clock-enable prescaler, auto-reload and sticky
// overflow/underflow/compare flags. Fully synchronous to a single clock.
module timer_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIV_BITS = 3
) (
    input  logic                timer_counter_clk,
    input  logic                timer_counter_reset_n,
    input  logic                timer_counter_enable,
    input  logic                timer_counter_load,
    input  logic [WIDTH-1:0]    timer_counter_tdr,
    input  logic                timer_counter_up_down,
    input  logic                timer_counter_auto_reload,
    input  logic                timer_counter_div_en,
    input  logic [DIV_BITS-1:0] timer_counter_div_val,
    input  logic [WIDTH-1:0]    timer_counter_cmp_val,
    input  logic                timer_counter_clr_ovf,
    input  logic                timer_counter_clr_udf,
    input  logic                timer_counter_clr_cmp,
    output logic [WIDTH-1:0]    timer_counter_count,
    output logic                timer_counter_ovf_flag,
    output logic                timer_counter_udf_flag,
    output logic                timer_counter_cmp_flag,
    output logic                timer_counter_tick
);

    localparam int unsigned PRESC_W = (1 << DIV_BITS) - 1;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [PRESC_W-1:0] presc_q, presc_d, presc_term;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               tick_c, tick_q;
    logic               ovf_q, ovf_d, ovf_set;
    logic               udf_q, udf_d, udf_set;
    logic               cmp_q, cmp_d, cmp_set;

    // Terminal prescaler value 2^div_val-1, built as a thermometer mask.
    always_comb begin
        presc_term = '0;
        for (int i = 0; i < PRESC_W; i++) begin
            presc_term[i] = (i < int'(timer_counter_div_val));
        end
    end

    always_comb begin
        tick_c = timer_counter_enable & ~timer_counter_load &
                 (~timer_counter_div_en | (presc_q == presc_term));
        if (tick_c || timer_counter_load || !timer_counter_enable) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Load has priority over any tick and never raises a flag.
    always_comb begin
        count_d = count_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (timer_counter_load) begin
            count_d = timer_counter_tdr;
        end else if (tick_c) begin
            if (!timer_counter_up_down) begin
                if (count_q == CNT_MAX) begin
                    count_d = timer_counter_auto_reload ? timer_counter_tdr : '0;
                    ovf_set = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = timer_counter_auto_reload ? timer_counter_tdr : CNT_MAX;
                    udf_set = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // Set beats a coincident clear.
    always_comb begin
        cmp_set = tick_c & (count_d == timer_counter_cmp_val);
        ovf_d   = ovf_set | (ovf_q & ~timer_counter_clr_ovf);
        udf_d   = udf_set | (udf_q & ~timer_counter_clr_udf);
        cmp_d   = cmp_set | (cmp_q & ~timer_counter_clr_cmp);
    end

    always_ff @(posedge timer_counter_clk or negedge timer_counter_reset_n) begin
        if (!timer_counter_reset_n) begin
            presc_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            cmp_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            tick_q  <= tick_c;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            cmp_q   <= cmp_d;
        end
    end

    assign timer_counter_count    = count_q;
    assign timer_counter_ovf_flag = ovf_q;
    assign timer_counter_udf_flag = udf_q;
    assign timer_counter_cmp_flag = cmp_q;
    assign timer_counter_tick     = tick_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: an 8-bit and a 16-bit instance share the
// control inputs; expected values are hand-computed per step.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, load, up_down, auto_reload, div_en;
    logic [2:0]  div_val;
    logic        clr_ovf, clr_udf, clr_cmp;
    logic [7:0]  tdr8, cmp8, count8;
    logic [15:0] tdr16, cmp16, count16;
    logic        ovf8, udf8, cmpf8, tick8;
    logic        ovf16, udf16, cmpf16, tick16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    timer_counter #(.WIDTH(8), .DIV_BITS(3)) u_dut8 (
        .timer_counter_clk         (clk),
        .timer_counter_reset_n     (rst_n),
        .timer_counter_enable      (enable),
        .timer_counter_load        (load),
        .timer_counter_tdr         (tdr8),
        .timer_counter_up_down     (up_down),
        .timer_counter_auto_reload (auto_reload),
        .timer_counter_div_en      (div_en),
        .timer_counter_div_val     (div_val),
        .timer_counter_cmp_val     (cmp8),
        .timer_counter_clr_ovf     (clr_ovf),
        .timer_counter_clr_udf     (clr_udf),
        .timer_counter_clr_cmp     (clr_cmp),
        .timer_counter_count       (count8),
        .timer_counter_ovf_flag    (ovf8),
        .timer_counter_udf_flag    (udf8),
        .timer_counter_cmp_flag    (cmpf8),
        .timer_counter_tick        (tick8)
    );

    timer_counter #(.WIDTH(16), .DIV_BITS(3)) u_dut16 (
        .timer_counter_clk         (clk),
        .timer_counter_reset_n     (rst_n),
        .timer_counter_enable      (enable),
        .timer_counter_load        (load),
        .timer_counter_tdr         (tdr16),
        .timer_counter_up_down     (up_down),
        .timer_counter_auto_reload (auto_reload),
        .timer_counter_div_en      (div_en),
        .timer_counter_div_val     (div_val),
        .timer_counter_cmp_val     (cmp16),
        .timer_counter_clr_ovf     (clr_ovf),
        .timer_counter_clr_udf     (clr_udf),
        .timer_counter_clr_cmp     (clr_cmp),
        .timer_counter_count       (count16),
        .timer_counter_ovf_flag    (ovf16),
        .timer_counter_udf_flag    (udf16),
        .timer_counter_cmp_flag    (cmpf16),
        .timer_counter_tick        (tick16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; up_down = 1'b0; auto_reload = 1'b0;
        div_en = 1'b0; div_val = 3'd0; clr_ovf = 1'b0; clr_udf = 1'b0; clr_cmp = 1'b0;
        tdr8 = 8'h00; cmp8 = 8'hA0; tdr16 = 16'h0000; cmp16 = 16'hA000;
        #2;
        chk("reset_count", count8, 8'h00);
        chk("reset_flags", {ovf8, udf8, cmpf8, tick8}, 4'b0000);
        #10 rst_n = 1'b1;

        // Reset mid-count from 0x37.
        load = 1'b1; tdr8 = 8'h37;
        step();
        chk("load_37", count8, 8'h37);
        load = 1'b0; enable = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_count", count8, 8'h00);
        chk("async_reset_flags", {ovf8, udf8, cmpf8}, 3'b000);
        #1 rst_n = 1'b1;
        step();
        chk("restart_count", count8, 8'h01);

        // Up overflow, natural wrap.
        enable = 1'b0; load = 1'b1; tdr8 = 8'hFD;
        step();
        chk("load_fd", count8, 8'hFD);
        load = 1'b0; enable = 1'b1;
        step();
        chk("up_fe", count8, 8'hFE);
        step();
        chk("up_ff", count8, 8'hFF);
        chk("ovf_before", ovf8, 1'b0);
        step();
        chk("wrap_00", count8, 8'h00);
        chk("ovf_set", ovf8, 1'b1);
        step();
        chk("ovf_sticky", ovf8, 1'b1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_cleared", ovf8, 1'b0);

        // Down underflow with auto-reload to 3.
        enable = 1'b0; load = 1'b1; tdr8 = 8'h01;
        step();
        load = 1'b0; tdr8 = 8'h03; up_down = 1'b1; auto_reload = 1'b1; enable = 1'b1;
        step();
        chk("down_00", count8, 8'h00);
        chk("udf_before", udf8, 1'b0);
        step();
        chk("reload_03", count8, 8'h03);
        chk("udf_set", udf8, 1'b1);
        step();
        chk("down_02", count8, 8'h02);
        step();
        chk("down_01", count8, 8'h01);
        step();
        chk("down_00b", count8, 8'h00);
        step();
        chk("reload_03b", count8, 8'h03);
        clr_udf = 1'b1; auto_reload = 1'b0; up_down = 1'b0; enable = 1'b0;
        step();
        clr_udf = 1'b0;
        chk("udf_cleared", udf8, 1'b0);

        // Prescaler /4: count bumps on clk 4 and 8, tick registered with it.
        load = 1'b1; tdr8 = 8'h00;
        step();
        load = 1'b0; div_en = 1'b1; div_val = 3'd2; enable = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("presc_count_%0d", k), count8, k / 4);
            chk($sformatf("presc_tick_%0d", k), tick8, (k % 4) == 0);
        end

        // Compare match and set-beats-clear.
        enable = 1'b0; div_en = 1'b0; load = 1'b1; tdr8 = 8'h03; cmp8 = 8'h05;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        chk("cmp_04", {count8, cmpf8}, {8'h04, 1'b0});
        step();
        chk("cmp_05", {count8, cmpf8}, {8'h05, 1'b1});
        cmp8 = 8'h06; clr_cmp = 1'b1;
        step();
        chk("cmp_set_wins", {count8, cmpf8}, {8'h06, 1'b1});
        step();
        chk("cmp_cleared", {count8, cmpf8}, {8'h07, 1'b0});
        clr_cmp = 1'b0; enable = 1'b0; load = 1'b1; tdr8 = 8'h06;
        step();
        load = 1'b0;
        chk("cmp_not_by_load", {count8, cmpf8}, {8'h06, 1'b0});

        // 16-bit instance: load collides with a tick, then overflow at FFFF.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        enable = 1'b1; load = 1'b1; tdr16 = 16'h1234; cmp16 = 16'h1234;
        step();
        chk("w16_load_vs_tick", count16, 16'h1234);
        chk("w16_no_flags", {ovf16, udf16, cmpf16}, 3'b000);
        tdr16 = 16'hFFFE;
        step();
        load = 1'b0;
        chk("w16_load_fffe", count16, 16'hFFFE);
        step();
        chk("w16_ffff", {count16, ovf16}, {16'hFFFF, 1'b0});
        step();
        chk("w16_wrap", {count16, ovf16}, {16'h0000, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
